// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
//   game_state_t  : controller states
//   DEF_*         : default timing / miss-limit values for the controller
//   LFSR_TAP_MASK : taps 16,14,13,11 of the right-shifting 16-bit Fibonacci LFSR
//   lfsr_feedback : feedback bit for the next LFSR state
package mole_game_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GAP       = 2'd1,
        LIT       = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam int DEF_MOLE_CYCLES = 50_000_000;
    localparam int DEF_GAP_CYCLES  = 12_500_000;
    localparam int DEF_MAX_MISSES  = 3;

    // Bit 0 is tap 16, so taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic lfsr_feedback(input logic [15:0] state_in);
        return ^(state_in & LFSR_TAP_MASK);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting right with feedback entering bit 15.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads SEED
//   en    : advance one step per cycle while high
//   state : current LFSR contents
import mole_game_pkg::*;

module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_r;

    // Shift register update; SEED must be non-zero or the sequence locks up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SEED;
        end else if (en) begin
            state_r <= {lfsr_feedback(state_r), state_r[15:1]};
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer.
// Picks a mole from an LFSR (never the same as the previous one), lights it
// for MOLE_CYCLES, then leaves GAP_CYCLES dark. A rising edge on the lit
// mole's button is a hit; a timeout is a miss. MAX_MISSES misses end the game.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : level; begins a game from IDLE or GAME_OVER
//   buttons       : debounced active-high player buttons
//   mole_onehot   : lit mole (one-hot) or zero
//   mole_hit      : one-cycle pulse per hit (score increment)
//   score_restart : one-cycle pulse when a game starts (score clear)
//   misses        : misses in the current game
//   game_over     : high while the game has ended
import mole_game_pkg::*;

module mole_game_ctrl #(
    parameter int          NUM_MOLES   = 4,
    parameter int          MOLE_CYCLES = DEF_MOLE_CYCLES,
    parameter int          GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int          MAX_MISSES  = DEF_MAX_MISSES,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] buttons,
    output logic [NUM_MOLES-1:0] mole_onehot,
    output logic                 mole_hit,
    output logic                 score_restart,
    output logic [3:0]           misses,
    output logic                 game_over
);

    localparam int IDX_W   = $clog2(NUM_MOLES);
    localparam int TMR_MAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0]     MOLE_LOAD  = TMR_W'(MOLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]     GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0]     TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0]     TMR_ZERO   = TMR_W'(0);
    localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);
    localparam logic [NUM_MOLES-1:0] ONE_MOLE   = NUM_MOLES'(1);
    localparam logic [NUM_MOLES-1:0] NO_MOLE    = NUM_MOLES'(0);
    localparam logic [3:0]           MISS_LIMIT = 4'(MAX_MISSES);

    game_state_t          state_r;
    logic [TMR_W-1:0]     timer_r;
    logic [IDX_W-1:0]     prev_idx_r;
    logic [NUM_MOLES-1:0] buttons_q_r;
    logic [NUM_MOLES-1:0] mole_onehot_r;
    logic                 mole_hit_r;
    logic                 score_restart_r;
    logic                 game_over_r;
    logic [3:0]           misses_r;

    logic [15:0]          lfsr_s;
    logic                 lfsr_unused_s;
    logic [NUM_MOLES-1:0] edge_s;
    logic [IDX_W-1:0]     idx_raw_s;
    logic [IDX_W-1:0]     idx_next_s;
    logic [3:0]           misses_inc_s;
    logic                 hit_s;
    logic                 timer_zero_s;

    // Free-running: advancing in every state lets player timing perturb the pick.
    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .state (lfsr_s)
    );

    // Only the low index bits select a mole; the rest are intentionally dropped.
    assign lfsr_unused_s = ^lfsr_s[15:IDX_W];

    assign edge_s       = buttons & ~buttons_q_r;
    assign idx_raw_s    = lfsr_s[IDX_W-1:0];
    assign hit_s        = edge_s[prev_idx_r];
    assign timer_zero_s = (timer_r == TMR_ZERO);

    // Next mole index: bump past the previous mole so the same one never repeats.
    always_comb begin
        idx_next_s = idx_raw_s;
        if (idx_raw_s == prev_idx_r) begin
            idx_next_s = idx_raw_s + IDX_ONE;
        end else begin
            idx_next_s = idx_raw_s;
        end
    end

    // Saturating miss increment.
    always_comb begin
        misses_inc_s = misses_r;
        if (misses_r >= MISS_LIMIT) begin
            misses_inc_s = misses_r;
        end else begin
            misses_inc_s = misses_r + 4'd1;
        end
    end

    // Button history; reset to all ones so buttons held through reset give no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons_q_r <= {NUM_MOLES{1'b1}};
        end else begin
            buttons_q_r <= buttons;
        end
    end

    // Game sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            timer_r         <= TMR_ZERO;
            prev_idx_r      <= IDX_W'(0);
            mole_onehot_r   <= NO_MOLE;
            mole_hit_r      <= 1'b0;
            score_restart_r <= 1'b0;
            misses_r        <= 4'd0;
            game_over_r     <= 1'b0;
        end else begin
            mole_hit_r      <= 1'b0;
            score_restart_r <= 1'b0;
            case (state_r)
                IDLE, GAME_OVER: begin
                    if (start) begin
                        state_r         <= GAP;
                        score_restart_r <= 1'b1;
                        misses_r        <= 4'd0;
                        game_over_r     <= 1'b0;
                        timer_r         <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (timer_zero_s) begin
                        state_r       <= LIT;
                        mole_onehot_r <= ONE_MOLE << idx_next_s;
                        prev_idx_r    <= idx_next_s;
                        timer_r       <= MOLE_LOAD;
                    end else begin
                        timer_r <= timer_r - TMR_ONE;
                    end
                end
                LIT: begin
                    // A hit on the final lit cycle takes priority over the timeout.
                    if (hit_s) begin
                        state_r       <= GAP;
                        mole_hit_r    <= 1'b1;
                        mole_onehot_r <= NO_MOLE;
                        timer_r       <= GAP_LOAD;
                    end else if (timer_zero_s) begin
                        misses_r      <= misses_inc_s;
                        mole_onehot_r <= NO_MOLE;
                        if (misses_inc_s == MISS_LIMIT) begin
                            state_r     <= GAME_OVER;
                            game_over_r <= 1'b1;
                        end else begin
                            state_r <= GAP;
                            timer_r <= GAP_LOAD;
                        end
                    end else begin
                        timer_r <= timer_r - TMR_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign mole_onehot   = mole_onehot_r;
    assign mole_hit      = mole_hit_r;
    assign score_restart = score_restart_r;
    assign misses        = misses_r;
    assign game_over     = game_over_r;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Randomized scenario bench for mole_game_ctrl with a game-level reference model.
module tb_mole_game_ctrl;

    localparam int          NM   = 4;
    localparam int          MC   = 8;
    localparam int          GC   = 4;
    localparam int          MM   = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic [NM-1:0] buttons = 4'h0;
    logic [NM-1:0] mole_onehot;
    logic          mole_hit;
    logic          score_restart;
    logic [3:0]    misses;
    logic          game_over;

    mole_game_ctrl #(
        .NUM_MOLES   (NM),
        .MOLE_CYCLES (MC),
        .GAP_CYCLES  (GC),
        .MAX_MISSES  (MM),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .buttons       (buttons),
        .mole_onehot   (mole_onehot),
        .mole_hit      (mole_hit),
        .score_restart (score_restart),
        .misses        (misses),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Game-level model state
    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_prev;
    int b_prev = 0;
    int cur_idx = 0;
    int m_misses = 0;
    int m_hits = 0;
    int m_restarts = 0;
    int hit_pulses = 0;
    int restart_pulses = 0;
    logic [NM-1:0] last_oh = 4'h0;
    logic [NM-1:0] prev_oh = 4'h0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic b;
        b = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {b, v[15:1]};
    endfunction

    // LFSR reference: seeded at reset, one step per cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr      <= SEED;
            m_lfsr_prev <= SEED;
        end else begin
            m_lfsr_prev <= m_lfsr;
            m_lfsr      <= lfsr_step(m_lfsr);
        end
    end

    // Count every cycle each pulse output is high.
    always @(posedge clk) begin
        if (mole_hit)      hit_pulses     <= hit_pulses + 1;
        if (score_restart) restart_pulses <= restart_pulses + 1;
    end

    task automatic wait_for_mole(output bit ok);
        int cnt;
        int raw;
        logic [NM-1:0] want;
        ok  = 1'b0;
        cnt = 0;
        while (cnt < 64) begin
            @(negedge clk);
            cnt++;
            if (mole_onehot !== 4'h0) break;
        end
        total_cnt++;
        if (mole_onehot === 4'h0) begin
            $display("FAIL mole_timeout: no mole after %0d cycles", cnt);
            return;
        end
        pass_cnt++;
        total_cnt++;
        if (cnt != GC) $display("FAIL gap_length: got %0d want %0d", cnt, GC);
        else pass_cnt++;
        raw = int'(m_lfsr_prev[1:0]);
        if (raw == b_prev) raw = (raw + 1) % NM;
        want = 4'(1 << raw);
        total_cnt++;
        if (mole_onehot !== want) $display("FAIL mole_select: got %b want %b", mole_onehot, want);
        else pass_cnt++;
        b_prev  = raw;
        cur_idx = raw;
        prev_oh = last_oh;
        last_oh = mole_onehot;
        total_cnt++;
        if (hit_pulses != m_hits) $display("FAIL hit_pulse_count: got %0d want %0d", hit_pulses, m_hits);
        else pass_cnt++;
        total_cnt++;
        if (restart_pulses != m_restarts)
            $display("FAIL restart_pulse_count: got %0d want %0d", restart_pulses, m_restarts);
        else pass_cnt++;
        ok = 1'b1;
    endtask

    // action: 0 none, 1 correct, 2 wrong, 3 correct+wrong, 4 all held from the gap
    task automatic play_mole(input int action, input int hit_at);
        bit ok;
        int j;
        bit is_hit;
        logic [NM-1:0] press;
        buttons = (action == 4) ? 4'hF : 4'h0;
        wait_for_mole(ok);
        if (!ok) begin
            buttons = 4'h0;
            return;
        end
        case (action)
            1:       press = 4'(1 << cur_idx);
            2:       press = 4'(1 << ((cur_idx + 1) % NM));
            3:       press = 4'(1 << cur_idx) | 4'(1 << ((cur_idx + 1) % NM));
            default: press = 4'h0;
        endcase
        is_hit = (action == 1) || (action == 3);
        j = 0;
        while (j <= MC + 2) begin
            if (j == hit_at && action >= 1 && action <= 3) buttons = press;
            @(negedge clk);
            j++;
            if (mole_onehot === 4'h0) break;
        end
        if (is_hit) begin
            m_hits++;
            total_cnt++;
            if (j != hit_at + 1) $display("FAIL hit_latency: lit %0d cycles want %0d", j, hit_at + 1);
            else pass_cnt++;
            total_cnt++;
            if (mole_hit !== 1'b1) $display("FAIL hit_pulse: got %b want 1", mole_hit);
            else pass_cnt++;
        end else begin
            if (m_misses < MM) m_misses++;
            total_cnt++;
            if (j != MC) $display("FAIL lit_length: got %0d want %0d", j, MC);
            else pass_cnt++;
            total_cnt++;
            if (mole_hit !== 1'b0) $display("FAIL spurious_hit: got %b want 0 (action %0d)", mole_hit, action);
            else pass_cnt++;
        end
        total_cnt++;
        if (misses !== 4'(m_misses)) $display("FAIL misses: got %0d want %0d", misses, m_misses);
        else pass_cnt++;
        total_cnt++;
        if (game_over !== (m_misses == MM)) $display("FAIL game_over: got %b want %b", game_over, m_misses == MM);
        else pass_cnt++;
        buttons = 4'h0;
        if (m_misses == MM) begin
            repeat (3) @(negedge clk);
            total_cnt++;
            if (mole_onehot !== 4'h0 || game_over !== 1'b1 || misses !== 4'(MM))
                $display("FAIL game_over_hold: mole %b over %b misses %0d want 0000 1 %0d",
                         mole_onehot, game_over, misses, MM);
            else pass_cnt++;
        end
    endtask

    task automatic do_start(input bit keep);
        start = 1'b1;
        @(negedge clk);
        m_restarts++;
        m_misses = 0;
        total_cnt++;
        if (score_restart !== 1'b1) $display("FAIL restart_pulse: got %b want 1", score_restart);
        else pass_cnt++;
        total_cnt++;
        if (misses !== 4'd0 || game_over !== 1'b0)
            $display("FAIL start_clear: misses %0d over %b want 0 0", misses, game_over);
        else pass_cnt++;
        if (!keep) start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (mole_onehot !== 4'h0 || mole_hit !== 1'b0 || score_restart !== 1'b0 ||
            misses !== 4'd0 || game_over !== 1'b0)
            $display("FAIL reset_outputs: mole %b hit %b rst %b misses %0d over %b want all 0",
                     mole_onehot, mole_hit, score_restart, misses, game_over);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (mole_onehot !== 4'h0 || restart_pulses != 0)
            $display("FAIL idle_hold: mole %b restarts %0d want 0000 0", mole_onehot, restart_pulses);
        else pass_cnt++;
    endtask

    task automatic test_start_and_timing;
        do_start(1'b0);
        play_mole(0, 0);
    endtask

    task automatic test_hit;
        play_mole(1, $urandom_range(0, MC - 2));
        play_mole(3, $urandom_range(0, MC - 2));
    endtask

    task automatic test_hit_at_timeout;
        play_mole(1, MC - 1);
    endtask

    task automatic test_wrong_and_held;
        play_mole(2, $urandom_range(0, MC - 1));
        play_mole(4, 0);
    endtask

    task automatic test_misses_to_game_over;
        do_start(1'b0);
        repeat (MM) play_mole(0, 0);
    endtask

    task automatic test_start_held;
        do_start(1'b1);
        play_mole(0, 0);
        start = 1'b0;
        play_mole(0, 0);
        play_mole(0, 0);
    endtask

    task automatic test_random;
        repeat (150) begin
            if (m_misses == MM) do_start(1'b0);
            play_mole($urandom_range(0, 4), $urandom_range(0, MC - 1));
        end
    endtask

    task automatic test_no_repeat;
        if (m_misses == MM) do_start(1'b0);
        repeat (1000) begin
            play_mole(1, $urandom_range(0, MC - 1));
            total_cnt++;
            if (last_oh === prev_oh) $display("FAIL mole_repeat: %b twice in a row", last_oh);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_game;
        bit ok;
        int bad;
        play_mole(0, 0);
        if (m_misses == MM) begin
            do_start(1'b0);
            play_mole(0, 0);
        end
        wait_for_mole(ok);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (mole_onehot !== 4'h0 || misses !== 4'd0 || game_over !== 1'b0 ||
            mole_hit !== 1'b0 || score_restart !== 1'b0)
            $display("FAIL midgame_reset: mole %b misses %0d over %b hit %b rst %b want all 0",
                     mole_onehot, misses, game_over, mole_hit, score_restart);
        else pass_cnt++;
        b_prev   = 0;
        m_misses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (mole_onehot !== 4'h0 || score_restart !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL idle_after_reset: %0d active cycles want 0", bad);
        else pass_cnt++;
        do_start(1'b0);
        play_mole(1, 2);
        play_mole(0, 0);
    endtask

    initial begin
        test_reset;
        test_start_and_timing;
        test_hit;
        test_hit_at_timeout;
        test_wrong_and_held;
        test_misses_to_game_over;
        test_start_held;
        test_random;
        test_no_repeat;
        test_reset_mid_game;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        total_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
